// File: rtl/fwd_ctrl.sv
// Forwarding / hazard controller for the 5-stage core.
// Tracks destination info for EX, MEM and WB in shadow registers, produces the
// EX operand-mux selects, and freezes the pipeline while the Dcache services a
// MEM-stage access.
module fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_rt_imm,
    input  logic              flush,
    input  logic              dcache_stall,
    output logic [1:0]        rs_sel,
    output logic [1:0]        rt_sel,
    output logic              pipe_stall,
    output logic [CNT_W-1:0]  dwait_cnt
);

    typedef enum logic [0:0] {StRun, StDwait} state_e;

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelMem  = 2'b01;
    localparam logic [1:0] SelWb   = 2'b10;
    localparam logic [1:0] SelLoad = 2'b11;

    state_e state_q, state_d;

    // EX shadow stage
    logic              ex_valid_q;
    logic [REG_AW-1:0] ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              ex_reg_write_q;
    logic              ex_mem_read_q;
    logic              ex_mem_write_q;
    logic              ex_rt_imm_q;

    // MEM shadow stage; mem_write is kept so a store also counts as a Dcache access
    logic              mem_valid_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_reg_write_q;
    logic              mem_mem_read_q;
    logic              mem_mem_write_q;

    // WB shadow stage; its load flag is not kept since WB forwards write data either way
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              wb_reg_write_q;

    logic [CNT_W-1:0]  dwait_cnt_q;
    logic              mem_acc;

    assign mem_acc    = mem_valid_q & (mem_mem_read_q | mem_mem_write_q);
    assign pipe_stall = mem_acc & dcache_stall;
    assign dwait_cnt  = dwait_cnt_q;

    // Forward code for one source operand: MEM beats WB, x0 never forwards.
    function automatic logic [1:0] fwd_code(
        input logic [REG_AW-1:0] src,
        input logic              m_valid,
        input logic              m_reg_write,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_mem_read,
        input logic              w_valid,
        input logic              w_reg_write,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] code;
        code = SelNone;
        if (src != '0) begin
            if (m_valid && m_reg_write && (m_rd == src)) begin
                code = m_mem_read ? SelLoad : SelMem;
            end else if (w_valid && w_reg_write && (w_rd == src)) begin
                code = SelWb;
            end
        end
        return code;
    endfunction

    // Shadow pipeline: shift on every non-stalled cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_rt_imm_q     <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            mem_mem_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
        end else if (!pipe_stall) begin
            ex_valid_q      <= id_valid & ~flush;
            ex_rs1_q        <= id_rs1;
            ex_rs2_q        <= id_rs2;
            ex_rd_q         <= id_rd;
            ex_reg_write_q  <= id_reg_write;
            ex_mem_read_q   <= id_mem_read;
            ex_mem_write_q  <= id_mem_write;
            ex_rt_imm_q     <= id_rt_imm;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_mem_read_q  <= ex_mem_read_q;
            mem_mem_write_q <= ex_mem_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
        end
    end

    // Operand selects, decoded from stage registers only.
    always_comb begin
        rs_sel = SelNone;
        rt_sel = SelNone;
        if (ex_valid_q) begin
            rs_sel = fwd_code(ex_rs1_q, mem_valid_q, mem_reg_write_q, mem_rd_q, mem_mem_read_q,
                              wb_valid_q, wb_reg_write_q, wb_rd_q);
            // Stores carry an immediate offset but still need their data operand forwarded
            if (!ex_rt_imm_q || ex_mem_write_q) begin
                rt_sel = fwd_code(ex_rs2_q, mem_valid_q, mem_reg_write_q, mem_rd_q,
                                  mem_mem_read_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
            end
        end
    end

    // RUN/DWAIT state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // RUN/DWAIT next state: leave DWAIT on the access's completion cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (pipe_stall) state_d = StDwait;
            StDwait: if (!dcache_stall) state_d = StRun;
        endcase
    end

    // Saturating count of Dcache wait cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwait_cnt_q <= '0;
        end else if (pipe_stall && (dwait_cnt_q != '1)) begin
            dwait_cnt_q <= dwait_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: a hand-written vector table for the directed scenarios,
// then randomized traffic checked against an instruction-queue reference model.
module tb_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_rt_imm;
    logic        flush;
    logic        dcache_stall;
    logic [1:0]  rs_sel;
    logic [1:0]  rt_sel;
    logic        pipe_stall;
    logic [15:0] dwait_cnt;
    logic [1:0]  rs_sel_n;
    logic [1:0]  rt_sel_n;
    logic        pipe_stall_n;
    logic [1:0]  dwait_cnt_n;

    int n_pass = 0;
    int n_tot  = 0;

    fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rt_imm(id_rt_imm), .flush(flush),
        .dcache_stall(dcache_stall), .rs_sel(rs_sel), .rt_sel(rt_sel),
        .pipe_stall(pipe_stall), .dwait_cnt(dwait_cnt)
    );

    // Narrow counter copy to observe saturation.
    fwd_ctrl #(.REG_AW(5), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rt_imm(id_rt_imm), .flush(flush),
        .dcache_stall(dcache_stall), .rs_sel(rs_sel_n), .rt_sel(rt_sel_n),
        .pipe_stall(pipe_stall_n), .dwait_cnt(dwait_cnt_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
        bit       mw;
        bit       imm;
    } ins_t;

    typedef struct {
        ins_t     id;
        bit       fl;
        bit       ds;
        bit       rs;
        bit       ck;
        int       ers;
        int       ert;
        int       est;
        int       ecnt;
    } vec_t;

    vec_t tbl[$];
    ins_t mq[$];   // in-flight instructions: [0]=EX, [1]=MEM, [2]=WB
    int   m_cnt;
    int   m_cnt_n;

    function automatic ins_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit mr, bit mw, bit imm);
        ins_t t;
        t.v   = v;
        t.rs1 = 5'(rs1);
        t.rs2 = 5'(rs2);
        t.rd  = 5'(rd);
        t.rw  = rw;
        t.mr  = mr;
        t.mw  = mw;
        t.imm = imm;
        return t;
    endfunction

    function automatic ins_t alu(int rs1, int rs2, int rd);
        return mk(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic ins_t addi(int rs1, int rd);
        return mk(1'b1, rs1, 0, rd, 1'b1, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic ins_t lw(int rs1, int rd);
        return mk(1'b1, rs1, 0, rd, 1'b1, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic ins_t sw(int rs1, int rs2);
        return mk(1'b1, rs1, rs2, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction
    function automatic ins_t nop();
        return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic row(ins_t id, bit fl, bit ds, bit rs, bit ck, int ers, int ert, int est,
                       int ecnt);
        vec_t v;
        v.id = id; v.fl = fl; v.ds = ds; v.rs = rs; v.ck = ck;
        v.ers = ers; v.ert = ert; v.est = est; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic drive(ins_t id, bit fl, bit ds, bit rs);
        id_valid     = id.v;
        id_rs1       = id.rs1;
        id_rs2       = id.rs2;
        id_rd        = id.rd;
        id_reg_write = id.rw;
        id_mem_read  = id.mr;
        id_mem_write = id.mw;
        id_rt_imm    = id.imm;
        flush        = fl;
        dcache_stall = ds;
        rst          = rs;
    endtask

    task automatic chk(string name, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: nearest older producer of src wins; loads still in MEM give load data.
    function automatic int ref_fwd(bit [4:0] src);
        if (src == 5'd0) return 0;
        for (int k = 1; k < 3; k++) begin
            if (mq[k].v && mq[k].rw && mq[k].rd == src) begin
                if (k == 1) return mq[k].mr ? 3 : 1;
                return 2;
            end
        end
        return 0;
    endfunction

    function automatic int ref_stall(bit ds);
        return (mq[1].v && (mq[1].mr || mq[1].mw) && ds) ? 1 : 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < 3; k++) mq.push_back(nop());
        m_cnt   = 0;
        m_cnt_n = 0;
    endtask

    task automatic model_clock(ins_t id, bit fl, bit ds, bit rs);
        ins_t t;
        if (rs) begin
            model_reset();
        end else if (ref_stall(ds) != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_n < 3) m_cnt_n++;
        end else begin
            t   = id;
            t.v = id.v & ~fl;
            mq.push_front(t);
            void'(mq.pop_back());
        end
    endtask

    initial begin
        ins_t id;
        bit   fl, ds, rs;
        int   ers, ert;

        // Directed table: expectations are for the instruction currently in EX.
        row(nop(),          0, 0, 1, 0, 0, 0, 0, 0);
        row(nop(),          0, 0, 1, 0, 0, 0, 0, 0);
        row(alu(1, 2, 5),   0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(5, 3, 6),   0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 1, 0, 0, 0);  // sub sees add in MEM
        row(lw(1, 7),       0, 0, 0, 1, 0, 0, 0, 0);
        row(addi(11, 10),   0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(2, 7, 8),   0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 0, 2, 0, 0);  // load now in WB
        row(lw(1, 7),       0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(2, 7, 8),   0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 0, 3, 0, 0);  // load in MEM
        row(addi(1, 4),     0, 0, 0, 1, 0, 0, 0, 0);
        row(addi(4, 4),     0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(4, 4, 9),   0, 0, 0, 1, 1, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 1, 1, 0, 0);  // MEM beats WB
        row(addi(4, 0),     0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(0, 0, 11),  0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 0, 0, 0, 0);  // x0 never forwarded
        row(alu(1, 2, 5),   0, 0, 0, 1, 0, 0, 0, 0);
        row(sw(1, 5),       0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 0, 1, 0, 0);  // store data forwarded
        row(lw(1, 7),       0, 0, 0, 1, 0, 0, 0, 0);
        row(alu(2, 7, 8),   0, 0, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 1, 0, 1, 0, 3, 1, 0);
        row(nop(),          0, 1, 0, 1, 0, 3, 1, 1);
        row(nop(),          1, 1, 0, 1, 0, 3, 1, 2);  // flush during stall
        row(alu(8, 0, 13),  0, 0, 0, 1, 0, 3, 0, 3);  // completion cycle
        row(nop(),          0, 1, 0, 1, 1, 0, 0, 3);  // add x8 survived; no access, no stall
        row(alu(1, 2, 5),   1, 0, 0, 1, 0, 0, 0, 3);
        row(alu(5, 5, 12),  0, 0, 0, 1, 0, 0, 0, 3);
        row(nop(),          0, 0, 0, 1, 0, 0, 0, 3);  // flushed add x5 not forwarded
        row(lw(1, 7),       0, 0, 0, 1, 0, 0, 0, 3);
        row(alu(2, 7, 8),   0, 0, 0, 1, 0, 0, 0, 3);
        row(nop(),          0, 1, 0, 1, 0, 3, 1, 3);
        row(nop(),          0, 1, 0, 1, 0, 3, 1, 4);
        row(nop(),          0, 1, 1, 1, 0, 3, 1, 5);  // reset mid-DWAIT
        row(nop(),          0, 1, 0, 1, 0, 0, 0, 0);
        row(nop(),          0, 0, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].id, tbl[i].fl, tbl[i].ds, tbl[i].rs);
            @(negedge clk);
            if (tbl[i].ck) begin
                chk($sformatf("row%0d rs_sel", i), int'(rs_sel), tbl[i].ers);
                chk($sformatf("row%0d rt_sel", i), int'(rt_sel), tbl[i].ert);
                chk($sformatf("row%0d pipe_stall", i), int'(pipe_stall), tbl[i].est);
                chk($sformatf("row%0d dwait_cnt", i), int'(dwait_cnt), tbl[i].ecnt);
                chk($sformatf("row%0d dwait_cnt_w2", i), int'(dwait_cnt_n),
                    (tbl[i].ecnt > 3) ? 3 : tbl[i].ecnt);
            end
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        drive(nop(), 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            id = mk($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1, 1'b0, 1'b0,
                    $urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0, 1:    begin id.mr = 1'b1; id.rw = 1'b1; end
                2:       begin id.mw = 1'b1; id.rw = 1'b0; id.imm = 1'b1; end
                default: ;
            endcase
            fl = $urandom_range(0, 99) < 10;
            ds = $urandom_range(0, 99) < 35;
            rs = $urandom_range(0, 99) < 1;
            drive(id, fl, ds, rs);
            @(negedge clk);
            ers = mq[0].v ? ref_fwd(mq[0].rs1) : 0;
            ert = (mq[0].v && (!mq[0].imm || mq[0].mw)) ? ref_fwd(mq[0].rs2) : 0;
            chk($sformatf("rnd%0d rs_sel", c), int'(rs_sel), ers);
            chk($sformatf("rnd%0d rt_sel", c), int'(rt_sel), ert);
            chk($sformatf("rnd%0d pipe_stall", c), int'(pipe_stall), ref_stall(ds));
            chk($sformatf("rnd%0d dwait_cnt", c), int'(dwait_cnt), m_cnt);
            chk($sformatf("rnd%0d rs_sel_w2", c), int'(rs_sel_n), ers);
            chk($sformatf("rnd%0d rt_sel_w2", c), int'(rt_sel_n), ert);
            chk($sformatf("rnd%0d pipe_stall_w2", c), int'(pipe_stall_n), ref_stall(ds));
            chk($sformatf("rnd%0d dwait_cnt_w2", c), int'(dwait_cnt_n), m_cnt_n);
            @(posedge clk);
            model_clock(id, fl, ds, rs);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
